// File: rtl/switch_debouncer_pkg.sv
// Shared constants for the switch debouncer: parameter defaults and the
// memory-mapped addresses the processor uses to reach switches and LEDs.
package switch_debouncer_pkg;

    localparam int N_SW_DEFAULT         = 16;
    localparam int TICK_DIV_DEFAULT     = 50000;
    localparam int STABLE_TICKS_DEFAULT = 4;

    localparam logic [15:0] SW_ADDR  = 16'h8000;
    localparam logic [15:0] LED_ADDR = 16'h8008;

    // Stable counter must be able to hold the value STABLE_TICKS.
    function automatic int cnt_width(input int stable_ticks);
        return $clog2(stable_ticks + 1);
    endfunction

endpackage

// File: rtl/switch_debouncer_debounce_cell.sv
// One debounced switch bit: 2-flop synchronizer, stable-sample counter and
// the accepted output level. Advances only on prescaler ticks.
module debounce_cell
    import switch_debouncer_pkg::*;
#(
    parameter int STABLE_TICKS = STABLE_TICKS_DEFAULT
) (
    input  logic i_mclk,
    input  logic i_reset,
    input  logic i_raw,
    input  logic i_tick,
    output logic o_bit,
    output logic o_accept
);

    localparam int                 CNT_W    = cnt_width(STABLE_TICKS);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(STABLE_TICKS - 1);

    logic             r_meta;
    logic             r_sync;
    logic             r_bit;
    logic [CNT_W-1:0] r_cnt;
    logic             w_differ;

    assign w_differ = r_sync ^ r_bit;
    assign o_accept = i_tick & w_differ & (r_cnt == CNT_LAST);
    assign o_bit    = r_bit;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values; blocking here would collapse the 2-flop chain.
    always_ff @(posedge i_mclk or negedge i_reset) begin
        if (!i_reset) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_raw;
            r_sync <= r_meta;
        end
    end

    always_ff @(posedge i_mclk or negedge i_reset) begin
        if (!i_reset) begin
            r_cnt <= '0;
            r_bit <= 1'b0;
        end else if (i_tick) begin
            if (!w_differ) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_bit <= r_sync;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/switch_debouncer.sv
// Debounces N_SW board switches for the processor's switch read word and
// reports per-bit sticky change flags plus a one-cycle change pulse.
module switch_debouncer
    import switch_debouncer_pkg::*;
#(
    parameter int N_SW         = N_SW_DEFAULT,
    parameter int TICK_DIV     = TICK_DIV_DEFAULT,
    parameter int STABLE_TICKS = STABLE_TICKS_DEFAULT
) (
    input  logic            i_mclk,
    input  logic            i_reset,
    input  logic [N_SW-1:0] i_sw,
    input  logic            i_clr,
    output logic [N_SW-1:0] o_sw,
    output logic            o_change,
    output logic [N_SW-1:0] o_changed
);

    localparam int                 PRESC_W    = $clog2(TICK_DIV);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

    if (TICK_DIV < 2 || TICK_DIV > (1 << 20)) begin : g_bad_tick_div
        $error("switch_debouncer: TICK_DIV out of range 2..2^20");
    end
    if (STABLE_TICKS < 1 || STABLE_TICKS > 15) begin : g_bad_stable
        $error("switch_debouncer: STABLE_TICKS out of range 1..15");
    end

    logic [PRESC_W-1:0] r_presc;
    logic               w_tick;
    logic [N_SW-1:0]    w_accept;
    logic               r_change;
    logic [N_SW-1:0]    r_changed;

    assign w_tick = (r_presc == PRESC_LAST);

    always_ff @(posedge i_mclk or negedge i_reset) begin
        if (!i_reset) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + PRESC_W'(1);
        end
    end

    for (genvar g = 0; g < N_SW; g++) begin : g_cell
        debounce_cell #(
            .STABLE_TICKS (STABLE_TICKS)
        ) u_cell (
            .i_mclk   (i_mclk),
            .i_reset  (i_reset),
            .i_raw    (i_sw[g]),
            .i_tick   (w_tick),
            .o_bit    (o_sw[g]),
            .o_accept (w_accept[g])
        );
    end

    // A new acceptance is ORed in after the clear, so set wins over i_clr.
    always_ff @(posedge i_mclk or negedge i_reset) begin
        if (!i_reset) begin
            r_change  <= 1'b0;
            r_changed <= '0;
        end else begin
            r_change  <= |w_accept;
            r_changed <= (r_changed & ~{N_SW{i_clr}}) | w_accept;
        end
    end

    assign o_change  = r_change;
    assign o_changed = r_changed;

endmodule

// File: tb/tb_switch_debouncer.sv
// Self-checking bench for switch_debouncer: fixed vectors, reset and
// prescaler corner sequences, then random switching against a reference model.
module tb_switch_debouncer;

    localparam int N_SW         = 16;
    localparam int TICK_DIV     = 4;
    localparam int STABLE_TICKS = 3;

    logic            clk   = 1'b0;
    logic            rst_n = 1'b0;
    logic [N_SW-1:0] sw    = '0;
    logic            clr   = 1'b0;
    logic [N_SW-1:0] o_sw;
    logic            o_change;
    logic [N_SW-1:0] o_changed;

    int checks = 0;
    int errors = 0;

    switch_debouncer #(
        .N_SW         (N_SW),
        .TICK_DIV     (TICK_DIV),
        .STABLE_TICKS (STABLE_TICKS)
    ) dut (
        .i_mclk    (clk),
        .i_reset   (rst_n),
        .i_sw      (sw),
        .i_clr     (clr),
        .o_sw      (o_sw),
        .o_change  (o_change),
        .o_changed (o_changed)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: edges counted since reset release, raw inputs kept
    // per edge, and a per-bit run length of tick samples disagreeing with o_sw.
    int              m_k;
    logic [N_SW-1:0] m_hist[$];
    int              m_run[N_SW];
    logic [N_SW-1:0] m_sw;
    logic [N_SW-1:0] m_changed;
    logic            m_change;

    task automatic model_reset();
        m_k = 0;
        m_hist.delete();
        for (int i = 0; i < N_SW; i++) m_run[i] = 0;
        m_sw      = '0;
        m_changed = '0;
        m_change  = 1'b0;
    endtask

    task automatic model_edge();
        logic [N_SW-1:0] seen;
        logic [N_SW-1:0] acc;
        seen = (m_hist.size() == 2) ? m_hist[0] : '0;
        acc  = '0;
        if (m_k % TICK_DIV == TICK_DIV - 1) begin
            for (int i = 0; i < N_SW; i++) begin
                if (seen[i] != m_sw[i]) begin
                    m_run[i]++;
                    if (m_run[i] == STABLE_TICKS) begin
                        acc[i]   = 1'b1;
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
        end
        m_changed = (clr ? '0 : m_changed) | acc;
        m_sw      = m_sw ^ acc;
        m_change  = |acc;
        m_hist.push_back(sw);
        if (m_hist.size() > 2) void'(m_hist.pop_front());
        m_k++;
    endtask

    task automatic step();
        if (rst_n) model_edge();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [N_SW-1:0] sw;
        logic            clr;
        int              cycles;
        logic [N_SW-1:0] exp_sw;
        logic [N_SW-1:0] exp_changed;
        int              exp_pulses;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int pulses;

        // Phases run back to back from reset release; ticks fall on edges 3,7,11,...
        tbl[0] = '{16'h0000, 1'b0, 100, 16'h0000, 16'h0000, 0}; // idle
        tbl[1] = '{16'h0001, 1'b0,   8, 16'h0000, 16'h0000, 0}; // bit0 seen on 2 ticks
        tbl[2] = '{16'h0000, 1'b0,  12, 16'h0000, 16'h0000, 0}; // glitch rejected
        tbl[3] = '{16'h0005, 1'b0,  16, 16'h0005, 16'h0005, 1}; // accept after 3 ticks
        tbl[4] = '{16'h000D, 1'b0,  11, 16'h0005, 16'h0005, 0}; // bit3 pending
        tbl[5] = '{16'h000D, 1'b1,   1, 16'h000D, 16'h0008, 1}; // clr with accept
        tbl[6] = '{16'h000D, 1'b0,   1, 16'h000D, 16'h0008, 0};
        tbl[7] = '{16'h000D, 1'b1,   1, 16'h000D, 16'h0000, 0}; // plain clear

        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_sw", o_sw, '0);
        check("rst_change", o_change, 1'b0);
        check("rst_changed", o_changed, '0);
        rst_n = 1'b1;
        model_reset();

        for (int r = 0; r < 8; r++) begin
            sw     = tbl[r].sw;
            clr    = tbl[r].clr;
            pulses = 0;
            for (int c = 0; c < tbl[r].cycles; c++) begin
                step();
                if (o_change) pulses++;
            end
            clr = 1'b0;
            check($sformatf("vec%0d_sw", r), o_sw, tbl[r].exp_sw);
            check($sformatf("vec%0d_changed", r), o_changed, tbl[r].exp_changed);
            check($sformatf("vec%0d_pulses", r), pulses, tbl[r].exp_pulses);
        end

        // Partial count on all bits, then a one-cycle reset mid-count.
        sw = 16'hFFFF;
        repeat (10) step();
        check("pre_rst_sw", o_sw, 16'h000D);
        rst_n = 1'b0;
        #1;
        check("midrst_sw", o_sw, '0);
        check("midrst_change", o_change, 1'b0);
        check("midrst_changed", o_changed, '0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Prescaler phase from release, and FFFF accepted on edge 11 exactly.
        for (int k = 0; k < 20; k++) begin
            check($sformatf("tick_e%0d", k), dut.w_tick, (k % TICK_DIV) == TICK_DIV - 1);
            step();
            if (k == 10) begin
                check("post_rst_hold_sw", o_sw, '0);
                check("post_rst_hold_change", o_change, 1'b0);
            end
            if (k == 11) begin
                check("post_rst_sw", o_sw, 16'hFFFF);
                check("post_rst_changed", o_changed, 16'hFFFF);
                check("post_rst_change", o_change, 1'b1);
            end
            if (k == 12) check("post_rst_pulse_end", o_change, 1'b0);
        end

        // Random switching against the model, with one reset mid-run.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(7) == 0) sw = sw ^ 16'($urandom);
            clr = ($urandom_range(15) == 0);
            if (n == 1500) begin
                rst_n = 1'b0;
                #1;
                check("rnd_rst_sw", o_sw, '0);
                model_reset();
                @(posedge clk);
                #1;
                rst_n = 1'b1;
            end
            step();
            check("rnd_sw", o_sw, m_sw);
            check("rnd_changed", o_changed, m_changed);
            check("rnd_change", o_change, m_change);
        end
        clr = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/switch_debouncer.md
SWITCH_DEBOUNCER -- requirements
Module: switch_debouncer

Interface
REQ-001 SHALL have parameter N_SW, default 16: number of switch channels.
REQ-002 SHALL have parameter TICK_DIV, default 50000: clock cycles per sample tick, legal range 2..2^20.
REQ-003 SHALL have parameter STABLE_TICKS, default 4: consecutive differing samples needed to accept a new level, legal range 1..15.
REQ-004 SHALL have port i_mclk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port i_reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port i_sw  input  N_SW  raw, asynchronous board switch levels.
REQ-007 SHALL have port i_clr  input  1  one-cycle pulse; clears sticky change mask (processor read of switch word).
REQ-008 SHALL have port o_sw  output  N_SW  debounced switch levels; drives the processor's switch read word.
REQ-009 SHALL have port o_change  output  1  one-cycle pulse; any bit of o_sw changed this cycle.
REQ-010 SHALL have port o_changed  output  N_SW  sticky per-bit change mask.

Function
REQ-011 Each i_sw bit SHALL pass a 2-flop synchronizer before any other use; sync value = i_sw delayed 2 cycles.
REQ-012 A prescaler SHALL count 0..TICK_DIV-1 and wrap to 0; tick = 1 for exactly the cycle the count equals TICK_DIV-1.
REQ-013 Per bit, on a tick cycle: sync != o_sw -> stable counter +1; sync == o_sw -> stable counter <= 0.
REQ-014 Per bit, on a tick where sync != o_sw and counter+1 == STABLE_TICKS: o_sw bit <= sync, counter <= 0, bit flagged changed.
REQ-015 Outside tick cycles, counters and o_sw SHALL hold.
REQ-016 A glitch (sync returns to o_sw before STABLE_TICKS differing ticks) SHALL reset that bit's counter and leave o_sw unchanged.
REQ-017 o_change SHALL be registered: 1 in the cycle after the edge that updated any o_sw bit, 0 otherwise; width exactly 1 cycle.
REQ-018 o_changed bit SHALL set on its o_sw update, clear on i_clr; same-cycle set and clear -> set wins.
REQ-019 Multiple bits accepted on the same tick SHALL all update o_sw in the same cycle and produce a single o_change pulse.
REQ-020 Counter width SHALL be clog2(STABLE_TICKS+1); prescaler width clog2(TICK_DIV); no counter wraps beyond its defined range.
REQ-021 Minimum latency raw edge -> o_sw = 2 sync cycles + up to STABLE_TICKS*TICK_DIV cycles; o_sw SHALL never change faster.

Reset
REQ-022 i_reset low SHALL immediately force: synchronizers 0, prescaler 0, all counters 0, o_sw 0, o_changed 0, o_change 0.
REQ-023 Reset asserted mid-count SHALL discard partial counts; after release debouncing restarts from o_sw = 0.
REQ-024 Switches high through reset SHALL appear on o_sw after STABLE_TICKS ticks post-release and SHALL set o_changed.

Structure
REQ-025 Shared package SHALL hold N_SW default, TICK_DIV/STABLE_TICKS defaults and the switch (0x8000) and LED (0x8008) MMIO address constants.
REQ-026 One sub-module debounce_cell (synchronizer + stable counter + output bit) SHALL be instantiated N_SW times; prescaler and o_change/o_changed logic live in switch_debouncer.

Verification (bench uses TICK_DIV=4, STABLE_TICKS=3)
REQ-027 Reset release, i_sw=0x0000 held 100 cycles -> o_sw=0x0000, o_change never 1, o_changed=0x0000.
REQ-028 i_sw 0x0000->0x0005 held -> o_sw=0x0005 after 3 ticks (<=2+12+1 cycles), one o_change pulse, o_changed=0x0005.
REQ-029 i_sw bit0 high for 2 ticks then low -> o_sw stays 0x0000, no o_change.
REQ-030 o_changed=0x0005, i_clr pulse same cycle bit3 accepted -> o_changed=0x0008.
REQ-031 i_sw=0xFFFF across reset, i_reset low mid-count for 1 cycle -> all outputs 0 immediately; o_sw=0xFFFF 3 ticks after release.
REQ-032 Prescaler check: tick asserted every 4th cycle exactly, first at cycle 3 after reset release.
